// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite bus bundle for the SRAM slave. Signal names follow the AHB
// convention so the bus can be wired straight to a decoder/mux fabric.
interface ahb_sram_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;

    // Bus side: master plus the fabric that returns the muxed HREADY.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// Parametrised AHB SRAM slave with a pipelined address/data phase, optional
// wait states, two-cycle ERROR responses for illegal transfers and
// read-after-write forwarding. Write data is taken in the data phase and
// committed on the edge that ends it, so a read accepted on that same edge
// sees the new lanes through the forwarding path rather than the array.
module ahb_sram_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 8192,
    parameter int WAIT_STATES = 0
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_sram_ctrl_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int K     = $clog2(NB);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int IW    = AW - K;
    localparam int DEPTH = MEM_BYTES / NB;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;

    typedef enum logic [2:0] {
        OKAY_IDLE,
        WAIT,
        OKAY_LAST,
        ERR1,
        ERR2
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic            hreadyout;
    logic [1:0]      hresp;

    // Address-phase decode
    logic            accept;
    logic            size_err, align_err, range_err, illegal;
    logic [31:0]     align_mask;
    logic [31:0]     lane_lo, lane_hi;
    logic [NB-1:0]   lane_en;
    logic [IW-1:0]   addr_idx;
    logic            rd_accept;

    // Data-phase (pending write) registers
    logic            wr_pend_reg;
    logic [IW-1:0]   wr_idx_reg;
    logic [NB-1:0]   wr_be_reg;
    logic            wr_commit;

    // Read path: raw array word plus the lanes forwarded from a same-edge write
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q_reg;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
    logic [NB-1:0]         fwd_mask_reg;
    logic                  rd_valid_reg;
    logic [DATA_WIDTH-1:0] rd_merged;

    logic unused_trans0;
    assign unused_trans0 = bus.HTRANS[0];

    assign accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign size_err   = bus.HSIZE > 3'(K);
    assign align_mask = (32'd1 << bus.HSIZE) - 32'd1;
    assign align_err  = |(bus.HADDR & align_mask);
    assign range_err  = {1'b0, bus.HADDR} >= MEM_LIMIT;
    assign illegal    = size_err | align_err | range_err;
    assign addr_idx   = bus.HADDR[AW-1:K];
    assign rd_accept  = accept & ~bus.HWRITE & ~illegal;

    // Lanes covered by the transfer: HADDR[K-1:0] up to +2^HSIZE-1.
    assign lane_lo = 32'(bus.HADDR[K-1:0]);
    assign lane_hi = lane_lo + (32'd1 << bus.HSIZE);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_en[gi] = (32'(gi) >= lane_lo) && (32'(gi) < lane_hi);
            assign rd_merged[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                           : ram_q_reg[8*gi +: 8];
        end
    endgenerate

    // A write lands on the edge that closes its data phase.
    assign wr_commit = wr_pend_reg & hreadyout;

    // Response FSM: next state, wait counter and the HREADYOUT/HRESP outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hreadyout  = 1'b1;
        hresp      = RESP_OKAY;
        case (state_reg)
            WAIT: begin
                hreadyout = 1'b0;
                if (cnt_reg == 3'd0) begin
                    state_next = OKAY_LAST;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ERR1: begin
                hreadyout  = 1'b0;
                hresp      = RESP_ERR;
                state_next = ERR2;
            end
            default: begin
                // OKAY_IDLE, OKAY_LAST and ERR2 all end a data phase and may accept.
                if (state_reg == ERR2) begin
                    hresp = RESP_ERR;
                end
                if (accept && illegal) begin
                    state_next = ERR1;
                end else if (accept && (WAIT_STATES > 0)) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = OKAY_IDLE;
                end
            end
        endcase
    end

    // Control state, pending write and forwarding capture; all cleared by reset
    // so an interrupted write can never reach the array.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg    <= OKAY_IDLE;
            cnt_reg      <= 3'd0;
            wr_pend_reg  <= 1'b0;
            wr_idx_reg   <= '0;
            wr_be_reg    <= '0;
            fwd_data_reg <= '0;
            fwd_mask_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wr_pend_reg <= bus.HWRITE & ~illegal;
                wr_idx_reg  <= addr_idx;
                wr_be_reg   <= lane_en;
            end else if (wr_commit) begin
                wr_pend_reg <= 1'b0;
            end
            if (rd_accept) begin
                rd_valid_reg <= 1'b1;
                fwd_data_reg <= bus.HWDATA;
                fwd_mask_reg <= (wr_commit && (wr_idx_reg == addr_idx)) ? wr_be_reg : '0;
            end
        end
    end

    // Memory array: byte-lane writes and registered read; contents survive reset.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_reg[i]) begin
                    mem[wr_idx_reg][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
        if (rd_accept) begin
            ram_q_reg <= mem[addr_idx];
        end
    end

    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign bus.HRDATA    = rd_valid_reg ? rd_merged : '0;
endmodule
